// File: rtl/ctrl_sequencer_pkg.sv
// ctrl_pkg: shared types for the multi-cycle control sequencer of the 9-bit
// accumulator-style ISA.
//   opcode_t   : 3-bit machine opcodes
//   alu_op_t   : ALU function select driven on Alu_op
//   state_t    : sequencer phases (the top maps these onto legacy
//                localparam constants)
//   opc_to_alu : opcode -> ALU function for the register-writing ops
package ctrl_pkg;

    localparam int OPC_W = 3;

    typedef enum logic [OPC_W-1:0] {
        OPC_ADD  = 3'b000,
        OPC_SUB  = 3'b001,
        OPC_AND  = 3'b010,
        OPC_LDI  = 3'b011,
        OPC_LD   = 3'b100,
        OPC_ST   = 3'b101,
        OPC_BRZ  = 3'b110,
        OPC_HALT = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_AND  = 2'b10,
        ALU_PASS = 2'b11
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    // LDI routes the immediate straight through the ALU; opcodes that do
    // not use the ALU fall back to ADD (the idle encoding).
    function automatic alu_op_t opc_to_alu(input opcode_t opc);
        case (opc)
            OPC_SUB: return ALU_SUB;
            OPC_AND: return ALU_AND;
            OPC_LDI: return ALU_PASS;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: bundle between the sequencer and its surroundings
// (instruction ROM, PC, register file, ALU, data memory).
//   master : the sequencer (inputs Start/Instruction/Instr_valid/Zero_flag,
//            drives all strobes and fields)
//   slave  : the datapath/testbench side
// Optional: CTRL_PERF_CNT_EN adds the 16-bit Retired_count output.
interface ctrl_sequencer_if #(
    parameter int RADDR_W = 3
);
    localparam int INSTR_W = 3 + 2*RADDR_W;
    localparam int IMM_W   = 2*RADDR_W;

    logic                 Start;
    logic [INSTR_W-1:0]   Instruction;
    logic                 Instr_valid;
    logic                 Zero_flag;
    logic                 Pc_en;
    logic                 Branch_taken;
    logic [INSTR_W-1:0]   Branch_offset;
    logic [1:0]           Alu_op;
    logic                 Reg_write_en;
    logic                 Immediate_en;
    logic [IMM_W-1:0]     Immediate;
    logic [RADDR_W-1:0]   Reg_write_address;
    logic [RADDR_W-1:0]   Reg_read_address_0;
    logic [RADDR_W-1:0]   Reg_read_address_1;
    logic                 Data_read_en;
    logic                 Data_write_en;
    logic                 Busy;
    logic                 Done;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0]          Retired_count;
`endif

    modport master (
`ifdef CTRL_PERF_CNT_EN
        output Retired_count,
`endif
        input  Start, Instruction, Instr_valid, Zero_flag,
        output Pc_en, Branch_taken, Branch_offset, Alu_op, Reg_write_en,
               Immediate_en, Immediate, Reg_write_address,
               Reg_read_address_0, Reg_read_address_1,
               Data_read_en, Data_write_en, Busy, Done
    );

    modport slave (
`ifdef CTRL_PERF_CNT_EN
        input  Retired_count,
`endif
        output Start, Instruction, Instr_valid, Zero_flag,
        input  Pc_en, Branch_taken, Branch_offset, Alu_op, Reg_write_en,
               Immediate_en, Immediate, Reg_write_address,
               Reg_read_address_0, Reg_read_address_1,
               Data_read_en, Data_write_en, Busy, Done
    );

endinterface

// File: rtl/ctrl_sequencer_decode.sv
// ctrl_decode: purely combinational field splitter for one instruction word.
//   instr    : instruction word (opcode | rA | rB, or opcode | imm)
//   opcode   : top OPC_W bits
//   ra, rb   : register fields
//   waddr    : destination register (R0 for LDI, rA otherwise)
//   imm      : low 2*RADDR_W bits, zero-extended by construction
//   imm_sext : imm sign-extended to the full instruction width
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int RADDR_W = 3
) (
    input  logic [OPC_W+2*RADDR_W-1:0] instr,
    output opcode_t                    opcode,
    output logic [RADDR_W-1:0]         ra,
    output logic [RADDR_W-1:0]         rb,
    output logic [RADDR_W-1:0]         waddr,
    output logic [2*RADDR_W-1:0]       imm,
    output logic [OPC_W+2*RADDR_W-1:0] imm_sext
);
    localparam int INSTR_W = OPC_W + 2*RADDR_W;
    localparam int IMM_W   = 2*RADDR_W;

    assign opcode = opcode_t'(instr[INSTR_W-1 -: OPC_W]);
    assign ra     = instr[IMM_W-1 -: RADDR_W];
    assign rb     = instr[RADDR_W-1:0];
    assign imm    = instr[IMM_W-1:0];
    assign waddr  = (opcode == OPC_LDI) ? '0 : ra;

    for (genvar gi = 0; gi < INSTR_W; gi++) begin : g_sext
        if (gi < IMM_W) begin : g_field
            assign imm_sext[gi] = instr[gi];
        end else begin : g_sign
            assign imm_sext[gi] = instr[IMM_W-1];
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle FSM controller for the 9-bit ISA.
//   Clk     : system clock
//   Reset_n : synchronous active-low reset
//   bus     : ctrl_sequencer_if.master (instruction in, datapath strobes out)
// Phases: IDLE -> FETCH -> DECODE -> EXEC -> [MEM x MEM_LAT] -> [WB] -> FETCH.
// Strobes are registered from the next state, so each is high for exactly
// the phase it belongs to. The only combinational paths are Pc_en and
// Branch_taken during EXEC of BRZ, which follow Zero_flag directly.
// Register addresses, Immediate and Branch_offset come straight from the
// latched instruction register, so they stay stable from DECODE until the
// next instruction is latched.
// Optional: CTRL_PERF_CNT_EN adds a saturating 16-bit Retired_count.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int RADDR_W = 3,
    parameter int MEM_LAT = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    ctrl_sequencer_if.master bus
);
    localparam int INSTR_W = OPC_W + 2*RADDR_W;
    localparam int IMM_W   = 2*RADDR_W;
    localparam int CNT_W   = 3;

    localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0] S_FETCH  = 3'(ST_FETCH);
    localparam logic [2:0] S_DECODE = 3'(ST_DECODE);
    localparam logic [2:0] S_EXEC   = 3'(ST_EXEC);
    localparam logic [2:0] S_MEM    = 3'(ST_MEM);
    localparam logic [2:0] S_WB     = 3'(ST_WB);

    logic [2:0]         state_reg, state_next;
    logic [INSTR_W-1:0] ir_reg, ir_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic       pc_en_reg, pc_en_next;
    logic       rwe_reg, rwe_next;
    logic       dre_reg, dre_next;
    logic       dwe_reg, dwe_next;
    logic       imm_en_reg, imm_en_next;
    logic       done_reg, done_next;
    logic       busy_reg, busy_next;
    logic [1:0] alu_op_reg, alu_op_next;

    opcode_t            dec_opcode;
    logic [RADDR_W-1:0] dec_ra, dec_rb, dec_waddr;
    logic [IMM_W-1:0]   dec_imm;
    logic [INSTR_W-1:0] dec_imm_sext;

    logic brz_exec;
    logic pc_en_o;
    logic branch_taken_o;

    ctrl_decode #(.RADDR_W(RADDR_W)) u_decode (
        .instr    (ir_reg),
        .opcode   (dec_opcode),
        .ra       (dec_ra),
        .rb       (dec_rb),
        .waddr    (dec_waddr),
        .imm      (dec_imm),
        .imm_sext (dec_imm_sext)
    );

    // Next-state, instruction latch and memory-wait counter.
    always_comb begin
        state_next = state_reg;
        ir_next    = ir_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.Start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (bus.Instr_valid) begin
                    ir_next    = bus.Instruction;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                case (dec_opcode)
                    OPC_ADD, OPC_SUB, OPC_AND, OPC_LDI: state_next = S_WB;
                    OPC_LD: begin
                        cnt_next   = CNT_W'(MEM_LAT - 1);
                        state_next = S_MEM;
                    end
                    OPC_ST, OPC_BRZ: state_next = S_FETCH;
                    OPC_HALT:        state_next = S_IDLE;
                    default:         state_next = S_IDLE;
                endcase
            end
            S_MEM: begin
                if (cnt_reg == '0) state_next = S_WB;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            S_WB:    state_next = S_FETCH;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes for the phase being entered. The instruction register is
    // already stable whenever EXEC/MEM/WB are entered, so the decoded
    // opcode is valid here.
    always_comb begin
        pc_en_next  = 1'b0;
        rwe_next    = 1'b0;
        dre_next    = 1'b0;
        dwe_next    = 1'b0;
        imm_en_next = 1'b0;
        done_next   = 1'b0;
        alu_op_next = 2'(ALU_ADD);
        busy_next   = (state_next != S_IDLE);
        case (state_next)
            S_EXEC: begin
                case (dec_opcode)
                    OPC_ADD, OPC_SUB, OPC_AND: alu_op_next = 2'(opc_to_alu(dec_opcode));
                    OPC_LDI: begin
                        alu_op_next = 2'(opc_to_alu(dec_opcode));
                        imm_en_next = 1'b1;
                    end
                    OPC_LD: dre_next = 1'b1;
                    OPC_ST: begin
                        dwe_next   = 1'b1;
                        pc_en_next = 1'b1;
                    end
                    OPC_HALT: done_next = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: dre_next = 1'b1;
            S_WB: begin
                rwe_next   = 1'b1;
                pc_en_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg  <= S_IDLE;
            ir_reg     <= '0;
            cnt_reg    <= '0;
            pc_en_reg  <= 1'b0;
            rwe_reg    <= 1'b0;
            dre_reg    <= 1'b0;
            dwe_reg    <= 1'b0;
            imm_en_reg <= 1'b0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            alu_op_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ir_reg     <= ir_next;
            cnt_reg    <= cnt_next;
            pc_en_reg  <= pc_en_next;
            rwe_reg    <= rwe_next;
            dre_reg    <= dre_next;
            dwe_reg    <= dwe_next;
            imm_en_reg <= imm_en_next;
            done_reg   <= done_next;
            busy_reg   <= busy_next;
            alu_op_reg <= alu_op_next;
        end
    end

    // BRZ resolves in EXEC from the live zero flag: taken and sequential
    // advance are mutually exclusive.
    assign brz_exec       = (state_reg == S_EXEC) && (dec_opcode == OPC_BRZ);
    assign branch_taken_o = brz_exec &  bus.Zero_flag;
    assign pc_en_o        = pc_en_reg | (brz_exec & ~bus.Zero_flag);

    assign bus.Pc_en              = pc_en_o;
    assign bus.Branch_taken       = branch_taken_o;
    assign bus.Branch_offset      = dec_imm_sext;
    assign bus.Alu_op             = alu_op_reg;
    assign bus.Reg_write_en       = rwe_reg;
    assign bus.Immediate_en       = imm_en_reg;
    assign bus.Immediate          = dec_imm;
    assign bus.Reg_write_address  = dec_waddr;
    assign bus.Reg_read_address_0 = dec_ra;
    assign bus.Reg_read_address_1 = dec_rb;
    assign bus.Data_read_en       = dre_reg;
    assign bus.Data_write_en      = dwe_reg;
    assign bus.Busy               = busy_reg;
    assign bus.Done               = done_reg;

`ifdef CTRL_PERF_CNT_EN
    // Counts every PC-affecting or retire pulse; cleared by an accepted Start.
    logic [15:0] retired_reg;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            retired_reg <= '0;
        end else if ((state_reg == S_IDLE) && bus.Start) begin
            retired_reg <= '0;
        end else if ((pc_en_o | branch_taken_o | done_reg) && (retired_reg != 16'hFFFF)) begin
            retired_reg <= retired_reg + 16'd1;
        end
    end

    assign bus.Retired_count = retired_reg;
`endif

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Multi-cycle control sequencer for the 9-bit accumulator-style ISA. It replaces the purely combinational decoder with an FSM. The FSM latches each instruction, drives register-file, ALU, data-memory and fetch-unit strobes phase by phase, absorbs a parametrised data-memory latency, and resolves branches from the ALU zero flag. It sits between instruction ROM and datapath; its outputs go to the program counter, register file, ALU and data memory.

Parameters:
RADDR_W, 3, register address width; INSTR_W = 3 + 2*RADDR_W (localparam, 9 by default)
MEM_LAT, 1, data-memory read latency in cycles (range 1..7)

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous, active-low reset
Start  in  1  one-cycle pulse; leaves IDLE
Instruction  in  INSTR_W  machine code from instruction ROM
Instr_valid  in  1  Instruction is valid this cycle
Zero_flag  in  1  ALU zero flag from previous compare/SUB
Pc_en  out  1  advance PC by 1 (one-cycle pulse)
Branch_taken  out  1  load PC with PC+Branch_offset (one-cycle pulse)
Branch_offset  out  INSTR_W  sign-extended 2*RADDR_W immediate
Alu_op  out  2  alu_op_t: ADD/SUB/AND/PASS
Reg_write_en  out  1  register-file write strobe
Immediate_en  out  1  select Immediate as ALU operand B
Immediate  out  2*RADDR_W  zero-extended immediate field
Reg_write_address  out  RADDR_W  destination register
Reg_read_address_0  out  RADDR_W  operand A
Reg_read_address_1  out  RADDR_W  operand B
Data_read_en  out  1  data-memory read, held for MEM_LAT cycles
Data_write_en  out  1  data-memory write (one-cycle pulse)
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle pulse on HALT retire

Behaviour:
- Fields: opcode = Instruction[INSTR_W-1 -: 3]; rA = next RADDR_W bits; rB = low RADDR_W bits; imm = low 2*RADDR_W bits.
- Opcodes: 000 ADD rA,rB; 001 SUB rA,rB; 010 AND rA,rB; 011 LDI imm (writes R0); 100 LD rA,[rB]; 101 ST rA,[rB]; 110 BRZ imm; 111 HALT.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- Reset (Reset_n=0 at posedge): state=IDLE, instruction register=0, memory counter=0, all outputs 0. This holds mid-operation; any in-flight strobe drops the next cycle.
- IDLE: on Start go to FETCH; Start is ignored in all other states.
- FETCH: wait for Instr_valid, then latch Instruction and go to DECODE. No timeout.
- DECODE: drive the read addresses from the latched fields (held stable until the next FETCH), then go to EXEC.
- EXEC:
  - ALU ops: Alu_op valid; go to WB.
  - LDI: Immediate_en=1, Alu_op=PASS; go to WB.
  - LD: Data_read_en=1, counter=MEM_LAT-1; go to MEM.
  - ST: Data_write_en pulse and Pc_en pulse; go to FETCH.
  - BRZ: if Zero_flag, Branch_taken=1 and Pc_en=0, else Pc_en=1 (mutually exclusive); go to FETCH.
  - HALT: Done=1; go to IDLE without advancing PC.
- MEM: Data_read_en held; counter decrements; go to WB when counter==0. With MEM_LAT=1 this is exactly one cycle.
- WB: Reg_write_en=1, Pc_en=1; go to FETCH.
- Write address: rA for ALU and LD, 0 for LDI.
- Latency: ALU op 4 cycles FETCH->FETCH (Instr_valid immediate); LD 4+MEM_LAT; ST/BRZ 3.
- Branch_offset = sign-extend(imm) to INSTR_W; wrap is the PC's concern.
- Strobes are registered outputs (Moore) except Branch_taken/Pc_en in EXEC-BRZ, which depend combinationally on Zero_flag.

Optional Feature:
CTRL_PERF_CNT_EN: when defined, adds output Retired_count (16 bits). It increments on every Pc_en, Branch_taken or Done pulse, saturates at 0xFFFF, and clears on reset and on Start. When undefined, the port and logic are absent.

Decomposition:
- Package ctrl_pkg: opcode_t enum (8 codes), alu_op_t enum, state_t enum, OPC_W=3.
- One natural sub-module: ctrl_decode, a combinational field/opcode decoder. It is instantiated once on the latched instruction register.

Test Plan:
- Reset_n=0 mid-LD (state MEM) -> next cycle all outputs 0, Busy=0, state IDLE; Start then fetches normally.
- Start; Instruction=9'b000_010_011 (ADD R2,R3), Instr_valid=1 -> read addrs 2/3 in DECODE; Reg_write_en & Pc_en in WB, cycle 4, write addr 2.
- MEM_LAT=3, LD R1,[R4] -> Data_read_en high exactly 4 cycles (EXEC + 3 MEM); Reg_write_en the next cycle.
- BRZ imm=6'b111110 with Zero_flag=1 -> Branch_taken=1, Branch_offset=9'h1FE, Pc_en=0; with Zero_flag=0 -> Pc_en=1 only.
- LDI 6'h2A -> Immediate=0x2A, Immediate_en=1, write addr 0; Instr_valid held low 5 cycles in FETCH -> no strobes.
- HALT -> Done pulse, Busy falls, no Pc_en; with CTRL_PERF_CNT_EN after 3 ALU ops + HALT, Retired_count=4.
